// File: rtl/key_event_pkg.sv
// Shared types and clock-derived defaults for the push-button conditioner.
// Types only: no latency and no backpressure apply.
package key_event_pkg;

  typedef struct packed {
    logic pressed;
    logic neg;
    logic pos;
    logic long_p;
  } key_chan_evt_t;

  // 10 ms and 1 s at the 12 MHz audio clock
  localparam int DEB_12M_10MS = 120000;
  localparam int LONG_12M_1S  = 12000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: sync, debounce and edge pulses, plus an optional long-press hold counter (KEY_LONG_PRESS_EN).
// Latency: raw edge sampled at E0 -> level/pulse at E0+1+DEBOUNCE_CYCLES; long pulse LONG_CYCLES after the level rises.
// No backpressure: pulses are single-cycle and are not held.
module key_debounce_ch
  import key_event_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEB_12M_10MS,
  parameter int LONG_CYCLES     = LONG_12M_1S
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_key,
  output key_chan_evt_t o_evt,
  output logic          o_neg_nxt
);

  localparam logic REL = (ACTIVE_LOW != 0);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          ff1, ff2;
  logic          s, mismatch, accept;
  logic [CW-1:0] cnt;
  logic          pressed_q, neg_q, pos_q, long_q;

  assign s        = ff2 ^ REL;
  assign mismatch = (s != pressed_q);
  assign accept   = mismatch && (cnt == CNT_LAST);
  assign o_neg_nxt = accept && s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ff1       <= REL;
      ff2       <= REL;
      cnt       <= '0;
      pressed_q <= 1'b0;
      neg_q     <= 1'b0;
      pos_q     <= 1'b0;
    end else begin
      ff1   <= i_key;
      ff2   <= ff1;
      neg_q <= 1'b0;
      pos_q <= 1'b0;
      if (!mismatch) begin
        cnt <= '0;
      end else if (accept) begin
        // terminal count clears the counter, so it can never wrap
        cnt       <= '0;
        pressed_q <= s;
        neg_q     <= s;
        pos_q     <= !s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold   <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!pressed_q) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        // saturating at the limit gives exactly one pulse per press
        hold   <= hold + 1'b1;
        long_q <= (hold == HOLD_MAX - 1'b1);
      end
    end
  end
`else
  assign long_q = 1'b0;
`endif

  assign o_evt = '{pressed: pressed_q, neg: neg_q, pos: pos_q, long_p: long_q};

endmodule

// File: rtl/key_event_unit.sv
// N-key push-button conditioner: per-key debounce channels plus a registered any-press flag (long press via KEY_LONG_PRESS_EN).
// Latency: E0+1+DEBOUNCE_CYCLES from raw edge to level/pulse; o_any_press aligned with o_neg.
// No backpressure: all outputs are free-running single-cycle pulses or levels.
module key_event_unit
  import key_event_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEB_12M_10MS,
  parameter int LONG_CYCLES     = LONG_12M_1S
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_keys,
  output logic [N_KEYS-1:0] o_pressed,
  output logic [N_KEYS-1:0] o_neg,
  output logic [N_KEYS-1:0] o_pos,
  output logic [N_KEYS-1:0] o_long,
  output logic              o_any_press
);

  key_chan_evt_t     evt [N_KEYS];
  logic [N_KEYS-1:0] neg_nxt;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_key     (i_keys[g]),
      .o_evt     (evt[g]),
      .o_neg_nxt (neg_nxt[g])
    );

    assign o_pressed[g] = evt[g].pressed;
    assign o_neg[g]     = evt[g].neg;
    assign o_pos[g]     = evt[g].pos;
    assign o_long[g]    = evt[g].long_p;
  end

  // built from the channels' next-state press terms so it lands with o_neg
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_any_press <= 1'b0;
    end else begin
      o_any_press <= |neg_nxt;
    end
  end

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: window-based debounce model checked every cycle, plus directed literal checks.
module tb_key_event_unit;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] keys = '1;
  logic [NK-1:0] o_pressed, o_neg, o_pos, o_long;
  logic          o_any_press;

  int checks = 0;
  int failures = 0;

  key_event_unit #(
    .N_KEYS          (NK),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_keys      (keys),
    .o_pressed   (o_pressed),
    .o_neg       (o_neg),
    .o_pos       (o_pos),
    .o_long      (o_long),
    .o_any_press (o_any_press)
  );

  always #5 clk = ~clk;

  // Model: a channel's level flips at edge j when the synchronised value
  // (raw sampled two edges earlier, released before that) differed from the
  // level on every one of the last DEB edges.
  logic [NK-1:0] smp_q[$];
  int            edge_n;
  logic [NK-1:0] m_lvl, m_neg, m_pos, m_long;
  int            press_edge [NK];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q.delete();
      edge_n = 0;
      m_lvl  = '0;
      m_neg  = '0;
      m_pos  = '0;
      m_long = '0;
    end else begin
      smp_q.push_back(~keys);
      m_neg  = '0;
      m_pos  = '0;
      m_long = '0;
      for (int c = 0; c < NK; c++) begin
        bit all_diff;
        bit old_lvl;
        all_diff = 1'b1;
        old_lvl  = m_lvl[c];
        for (int k = 0; k < DEB; k++) begin
          int  e;
          logic [NK-1:0] v;
          bit  sv;
          e  = edge_n - k;
          sv = 1'b0;
          if (e >= 2) begin
            v  = smp_q[e-2];
            sv = v[c];
          end
          if (sv == old_lvl) all_diff = 1'b0;
        end
`ifdef KEY_LONG_PRESS_EN
        if (old_lvl && (edge_n - press_edge[c] == LONG)) m_long[c] = 1'b1;
`endif
        if (all_diff) begin
          if (!old_lvl) begin
            m_neg[c] = 1'b1;
            press_edge[c] = edge_n;
          end else begin
            m_pos[c] = 1'b1;
          end
          m_lvl[c] = ~old_lvl;
        end
      end
      edge_n++;
    end
  end

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pressed", o_pressed, m_lvl);
    chk("model_neg", o_neg, m_neg);
    chk("model_pos", o_pos, m_pos);
    chk("model_long", o_long, m_long);
    chk("model_any", {3'b0, o_any_press}, {3'b0, |m_neg});
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    edges(3);
    chk("rst_pressed", o_pressed, 4'b0000);
    chk("rst_pulses", o_neg | o_pos | o_long, 4'b0000);
    chk("rst_any", {3'b0, o_any_press}, 4'b0000);
    rst_n = 1'b1;

    edges(50);
    chk("idle_pressed", o_pressed, 4'b0000);

    // key0 press: next edge is E0, pulse visible after E0+5
    keys = 4'b1110;
    edges(6);
    chk("k0_neg", o_neg, 4'b0001);
    chk("k0_any", {3'b0, o_any_press}, 4'b0001);
    chk("k0_pressed", o_pressed, 4'b0001);
    edges(1);
    chk("k0_neg_end", o_neg, 4'b0000);
    edges(19);
`ifdef KEY_LONG_PRESS_EN
    chk("k0_long", o_long, 4'b0001);
`else
    chk("k0_long_off", o_long, 4'b0000);
`endif
    edges(100);

    // key1 bounce shorter than the debounce window
    keys = 4'b1100;
    edges(3);
    keys = 4'b1110;
    edges(10);
    chk("k1_bounce", o_pressed, 4'b0001);

    // key2 and key3 together
    keys = 4'b0010;
    edges(6);
    chk("k23_neg", o_neg, 4'b1100);
    chk("k23_any", {3'b0, o_any_press}, 4'b0001);
    edges(10);
    keys = 4'b1110;
    edges(6);
    chk("k23_pos", o_pos, 4'b1100);
    chk("k23_pressed", o_pressed, 4'b0001);
    edges(5);

    // reset while key0 held and key1 mid-count
    keys = 4'b1100;
    edges(3);
    rst_n = 1'b0;
    #1;
    chk("arst_pressed", o_pressed, 4'b0000);
    chk("arst_pulses", o_neg | o_pos | o_long, 4'b0000);
    keys = 4'b1110;
    edges(3);
    rst_n = 1'b1;
    edges(6);
    chk("rerst_neg", o_neg, 4'b0001);
    chk("rerst_pressed", o_pressed, 4'b0001);
    edges(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
